// File: rtl/sdram_pkg.sv
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared widths, FSM state encoding and command record for the
//                SDRAM block-transfer initiator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package sdram_pkg;

    localparam int SDRAM_ADDR_W = 23;
    localparam int SDRAM_DATA_W = 16;
    localparam int SDRAM_LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } xfer_state_t;

    typedef struct packed {
        logic                    write;
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [SDRAM_LEN_W-1:0]  len;
    } xfer_cmd_t;

endpackage

`default_nettype wire

// File: rtl/sdram_block_xfer_if.sv
// ============================================================================
//  Module      : sdram_block_xfer_if
//  Description : Bundle of the command, write-stream, read-stream and
//                controller user-port signals of the block-transfer initiator.
//                slave  = view of the initiator itself
//                master = view of the surrounding logic / controller
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sdram_block_xfer_if
    import sdram_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int DATA_W = SDRAM_DATA_W,
    parameter int LEN_W  = SDRAM_LEN_W
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    // write-data stream
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    // read-data stream
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    // completion
    logic              xfer_done;
    logic              xfer_err;
    // controller user port
    logic              mem_ready;
    logic              mem_as;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  mem_ready, mem_rdata, mem_done,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output xfer_done, xfer_err,
        output mem_as, mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        output mem_ready, mem_rdata, mem_done,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  xfer_done, xfer_err,
        input  mem_as, mem_rw, mem_addr, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/sdram_xfer_wdog.sv
// ============================================================================
//  Module      : sdram_xfer_wdog
//  Description : Watchdog for an outstanding controller access. Counts cycles
//                while enabled; o_expired rises in the TIMEOUT_CYC-th enabled
//                cycle after the last clear.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_xfer_wdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // Cycle counter: restarts on every new access, freezes once expired.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/sdram_block_xfer.sv
// ============================================================================
//  Module      : sdram_block_xfer
//  Description : Initiator side of the SDRAM controller user port. Takes one
//                block command (base, length, direction) and performs one
//                single-word access per word at sequential addresses. Write
//                words come from a valid/ready stream; read words leave via a
//                1-entry buffer onto a valid/ready stream.
//  Options     : SDRAM_XFER_TIMEOUT_EN - adds a watchdog on each outstanding
//                access; expiry aborts the block with xfer_err.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_block_xfer
    import sdram_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int DATA_W = SDRAM_DATA_W,
    parameter int LEN_W  = SDRAM_LEN_W
`ifdef SDRAM_XFER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst,
    sdram_block_xfer_if.slave  bus
);

    xfer_state_t        r_state;
    xfer_state_t        w_next_state;

    // latched command / progress
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_remaining;

    // registered outputs
    logic               r_cmd_ready;
    logic               r_mem_as;
    logic               r_mem_rw;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_xfer_done;

    // 1-entry read buffer
    logic               r_rbuf_valid;
    logic [DATA_W-1:0]  r_rbuf_data;

    // FSM decodes
    logic               w_accept;
    logic               w_issue;
    logic               w_wr_ready;
    logic               w_word_done;
    logic               w_fin_pulse;
    logic               w_rd_pop;
    logic               w_path_clear;

`ifdef SDRAM_XFER_TIMEOUT_EN
    logic               w_timeout;
    logic               r_abort;
    logic               r_xfer_err;

    sdram_xfer_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_issue),
        .i_en      (r_state == WAIT),
        .o_expired (w_timeout)
    );
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle strobes. A read slot is free when the buffer is
    // empty or is being handed to the sink this very cycle.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_wr_ready   = 1'b0;
        w_word_done  = 1'b0;
        w_fin_pulse  = 1'b0;
        w_rd_pop     = r_rbuf_valid && bus.rd_ready;
        w_path_clear = r_write ? bus.wr_valid : (!r_rbuf_valid || w_rd_pop);

        case (r_state)
            IDLE: begin
                if (r_cmd_ready && bus.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = (bus.cmd_len == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready && w_path_clear) begin
                    w_issue      = 1'b1;
                    w_wr_ready   = r_write;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_done) begin
                    w_word_done  = 1'b1;
                    w_next_state = (r_remaining == LEN_W'(1)) ? FIN : ISSUE;
                end
`ifdef SDRAM_XFER_TIMEOUT_EN
                else if (w_timeout) begin
                    w_next_state = FIN;
                end
`endif
            end
            FIN: begin
                if (!r_rbuf_valid) begin
                    w_fin_pulse  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Command latch, address/count progress and controller-facing registers.
    // mem_rw/addr/wdata only change on issue, so they stay put until mem_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b0;
            r_mem_as    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_xfer_done <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            r_cmd_ready <= (w_next_state == IDLE);
            r_mem_as    <= w_issue;
            r_xfer_done <= w_fin_pulse;
            if (w_accept) begin
                r_write     <= bus.cmd_write;
                r_addr      <= bus.cmd_addr;
                r_remaining <= bus.cmd_len;
            end
            if (w_issue) begin
                r_mem_rw   <= !r_write;
                r_mem_addr <= r_addr;
                if (r_write) begin
                    r_mem_wdata <= bus.wr_data;
                end
            end
            if (w_word_done) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    // Read buffer: load on a read completion, drain on sink acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rbuf_valid <= 1'b0;
            r_rbuf_data  <= '0;
        end else if (w_word_done && !r_write) begin
            r_rbuf_valid <= 1'b1;
            r_rbuf_data  <= bus.mem_rdata;
        end else if (w_rd_pop) begin
            r_rbuf_valid <= 1'b0;
        end
    end

`ifdef SDRAM_XFER_TIMEOUT_EN
    // Remember an aborted block so the error flag accompanies its done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_abort    <= 1'b0;
            r_xfer_err <= 1'b0;
        end else begin
            r_xfer_err <= w_fin_pulse && r_abort;
            if (w_accept || w_fin_pulse) begin
                r_abort <= 1'b0;
            end else if (r_state == WAIT && !bus.mem_done && w_timeout) begin
                r_abort <= 1'b1;
            end
        end
    end

    assign bus.xfer_err = r_xfer_err;
`else
    assign bus.xfer_err = 1'b0;
`endif

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.wr_ready  = w_wr_ready;
    assign bus.rd_valid  = r_rbuf_valid;
    assign bus.rd_data   = r_rbuf_data;
    assign bus.xfer_done = r_xfer_done;
    assign bus.mem_as    = r_mem_as;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire
